// File: rtl/shift_reg_hex_pkg.sv
// Shared definitions for the pushbutton-clocked shift register with hex display.
// Latency: none (constants, types and pure helper functions only).
// Backpressure: not applicable; nothing here holds state.
package shift_reg_hex_pkg;

  // Largest register width the board can display (six seven-segment digits).
  localparam int WIDTH_MAX = 6;

  // Operating mode, taken from SW[8:7].
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_ROL  = 2'b11
  } mode_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Shift counter ceiling; the counter sticks here instead of wrapping.
  localparam logic [2:0] CNT_MAX = 3'd7;

  // Saturating increment for the shift counter.
  function automatic logic [2:0] cnt_sat_inc(input logic [2:0] cnt);
    return (cnt == CNT_MAX) ? CNT_MAX : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/bit_to_seg.sv
// Decodes one register bit into an active-low seven-segment '0'/'1' glyph.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs continuously.
module bit_to_seg
  import shift_reg_hex_pkg::*;
(
  input  logic       bit_val,
  input  logic       shown,
  output logic [6:0] seg
);

  // Blank until the first clock edge after reset, then show the bit value.
  always_comb begin
    seg = SEG_BLANK;
    if (shown) begin
      seg = bit_val ? SEG_1 : SEG_0;
    end
  end

endmodule

// File: rtl/shift_reg_hex.sv
// WIDTH-bit hold/load/shift/rotate register clocked by KEY[0], shown on LEDR and HEX.
// Latency: state updates on the KEY[0] rising edge; outputs are combinational from state.
// Backpressure: none; every rising edge performs exactly one operation.
module shift_reg_hex
  import shift_reg_hex_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [1:0]         KEY,
  input  logic [9:0]         SW,
  output logic [9:0]         LEDR,
  output logic [7*WIDTH-1:0] HEX
);

  // Refuse to build outside the range the board's LEDs and digits can represent.
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("shift_reg_hex: WIDTH must be in 1..6");
  end

  logic clk;
  logic rst_n;
  assign clk   = KEY[0];
  assign rst_n = KEY[1];

  // SW[6:WIDTH] exist on the board but carry no meaning for this register.
  logic sw_unused;
  assign sw_unused = ^SW[6:WIDTH];

  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             shown_q, shown_d;
  logic             shl_in;

  // Next-state selection by mode; the display un-blanks on any edge, even hold.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    shown_d = 1'b1;
    // Rotate feeds the MSB back in; shift takes the serial input pin.
    shl_in  = (mode_e'(SW[8:7]) == MODE_ROL) ? data_q[WIDTH-1] : SW[9];
    case (mode_e'(SW[8:7]))
      MODE_HOLD: begin
        data_d = data_q;
        cnt_d  = cnt_q;
      end
      MODE_LOAD: begin
        data_d = SW[WIDTH-1:0];
        cnt_d  = 3'd0;
      end
      MODE_SHL, MODE_ROL: begin
        // Concatenate then truncate so WIDTH=1 needs no special case:
        // the single bit simply becomes shl_in.
        data_d = WIDTH'({data_q, shl_in});
        cnt_d  = cnt_sat_inc(cnt_q);
      end
      default: begin
        data_d = data_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  // Register state on the pushbutton edge; a held reset overrides every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= 3'd0;
      shown_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      shown_q <= shown_d;
    end
  end

  // LED map: serial-out on 9, counter on 8:6, register mirror on the low bits.
  always_comb begin
    LEDR            = '0;
    LEDR[9]         = data_q[WIDTH-1];
    LEDR[8:6]       = cnt_q;
    LEDR[WIDTH-1:0] = data_q;
  end

  // One decoder per digit; digit i shows register bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_digit
    bit_to_seg u_bit_to_seg (
      .bit_val (data_q[i]),
      .shown   (shown_q),
      .seg     (HEX[7*i +: 7])
    );
  end

endmodule
